// File: rtl/chimera_cluster_pwr_seq_pkg.sv
// Shared types and defaults for the Chimera cluster power-state sequencer.
package chimera_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISO    = 3'd1,
    CLKOFF = 3'd2,
    RSTON  = 3'd3,
    CLKON  = 3'd4,
    RSTOFF = 3'd5,
    DEISO  = 3'd6,
    ABORT  = 3'd7
  } pwr_seq_state_e;

  localparam int unsigned DefaultRstCycles  = 32'd8;
  localparam int unsigned DefaultIsoTimeout = 32'd1024;

endpackage

// File: rtl/chimera_cluster_pwr_seq_chk.sv
// Output-invariant checker for chimera_cluster_pwr_seq; instantiate beside the sequencer.
module chimera_cluster_pwr_seq_chk #(
  parameter int unsigned NumClusters = 5
) (
  input logic                   clk,
  input logic                   rst,
  input logic [NumClusters-1:0] isolate,
  input logic [NumClusters-1:0] clkEn,
  input logic [NumClusters-1:0] clusterRst,
  input logic [NumClusters-1:0] on
);

  logic [NumClusters-1:0] dev_s;

  // A cluster deviates when any control differs from its committed on/off pattern.
  assign dev_s = (isolate ^ ~on) | (clkEn ^ on) | (clusterRst ^ ~on);

  aClkIso: assert property (@(posedge clk) disable iff (rst) (~clkEn & ~isolate) == '0)
    else $error("FAIL chk_clk_iso isolate=%b clkEn=%b", isolate, clkEn);

  aRstIso: assert property (@(posedge clk) disable iff (rst) (clusterRst & ~isolate) == '0)
    else $error("FAIL chk_rst_iso isolate=%b clusterRst=%b", isolate, clusterRst);

  aOneDev: assert property (@(posedge clk) disable iff (rst) $countones(dev_s) <= 32'sd1)
    else $error("FAIL chk_one_dev deviating=%b", dev_s);

endmodule

// File: rtl/chimera_cluster_pwr_seq_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr, wrapping.
module chimera_rr_pick #(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] gntIdx,
  output logic            valid
);

  logic [IdxW-1:0] cand_s;

  // Scan offsets from the far end so the nearest request to ptr is written last.
  always_comb begin
    gntIdx = '0;
    valid  = 1'b0;
    cand_s = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      cand_s = IdxW'((32'(ptr) + 32'(i)) % N);
      gntIdx = req[cand_s] ? cand_s : gntIdx;
      valid  = valid | req[cand_s];
    end
  end

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: one cluster at a time, round-robin, isolate/clock/reset ordering.
module chimera_cluster_pwr_seq
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned RstCycles   = DefaultRstCycles,
  parameter int unsigned IsoTimeout  = DefaultIsoTimeout,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] pwr_req_i,
  input  logic [NumClusters-1:0] isolated_i,
  input  logic                   err_clr_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic [NumClusters-1:0] on_o,
  output logic [NumClusters-1:0] err_o,
  output logic                   busy_o
);

  localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

  pwr_seq_state_e         state_r, stateNext_s;
  logic [CntWidth-1:0]    cnt_r, cntNext_s;
  logic [IdxW-1:0]        gnt_r, gntNext_s, rr_r, rrNext_s, pickIdx_s;
  logic                   dir_r, dirNext_s, pickValid_s, isoExpired_s;
  logic [NumClusters-1:0] on_r, onNext_s, iso_r, isoNext_s, clkEn_r, clkEnNext_s;
  logic [NumClusters-1:0] cRst_r, cRstNext_s, err_r, errNext_s, errSet_s, pend_s;
  logic                   busy_r, busyNext_s;

  assign pend_s       = pwr_req_i ^ on_r;
  assign isoExpired_s = (cnt_r == CntWidth'(IsoTimeout - 32'd1));

  chimera_rr_pick #(.N(NumClusters), .IdxW(IdxW)) uPick (
    .req    (pend_s),
    .ptr    (rr_r),
    .gntIdx (pickIdx_s),
    .valid  (pickValid_s)
  );

  // Next-state and next-output computation; only the granted cluster's bits are touched.
  always_comb begin
    stateNext_s = state_r;
    gntNext_s   = gnt_r;
    dirNext_s   = dir_r;
    rrNext_s    = rr_r;
    onNext_s    = on_r;
    isoNext_s   = iso_r;
    clkEnNext_s = clkEn_r;
    cRstNext_s  = cRst_r;
    errSet_s    = '0;
    case (state_r)
      IDLE: begin
        if (pickValid_s) begin
          gntNext_s = pickIdx_s;
          dirNext_s = pwr_req_i[pickIdx_s];
          rrNext_s  = (pickIdx_s == IdxW'(NumClusters - 32'd1)) ? '0 : pickIdx_s + IdxW'(1);
          if (pwr_req_i[pickIdx_s]) begin
            stateNext_s            = CLKON;
            clkEnNext_s[pickIdx_s] = 1'b1;
          end else begin
            stateNext_s          = ISO;
            isoNext_s[pickIdx_s] = 1'b1;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      ISO: begin
        if (isolated_i[gnt_r]) begin
          stateNext_s        = CLKOFF;
          clkEnNext_s[gnt_r] = 1'b0;
        end else if (isoExpired_s) begin
          stateNext_s = ABORT;
        end else begin
          stateNext_s = ISO;
        end
      end
      CLKOFF: begin
        stateNext_s       = RSTON;
        cRstNext_s[gnt_r] = 1'b1;
      end
      RSTON: begin
        stateNext_s     = IDLE;
        onNext_s[gnt_r] = 1'b0;
      end
      CLKON: begin
        if (cnt_r == CntWidth'(RstCycles - 32'd1)) begin
          stateNext_s       = RSTOFF;
          cRstNext_s[gnt_r] = 1'b0;
        end else begin
          stateNext_s = CLKON;
        end
      end
      RSTOFF: begin
        stateNext_s      = DEISO;
        isoNext_s[gnt_r] = 1'b0;
      end
      DEISO: begin
        if (!isolated_i[gnt_r]) begin
          stateNext_s     = IDLE;
          onNext_s[gnt_r] = 1'b1;
        end else if (isoExpired_s) begin
          stateNext_s = ABORT;
        end else begin
          stateNext_s = DEISO;
        end
      end
      ABORT: begin
        stateNext_s     = IDLE;
        errSet_s[gnt_r] = 1'b1;
        // Fall back to whichever committed state the cluster was leaving.
        if (dir_r) begin
          isoNext_s[gnt_r]   = 1'b1;
          clkEnNext_s[gnt_r] = 1'b0;
          cRstNext_s[gnt_r]  = 1'b1;
        end else begin
          isoNext_s[gnt_r] = 1'b0;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
    errNext_s  = (err_r & ~{NumClusters{err_clr_i}}) | errSet_s;
    // Stay busy across back-to-back sequences while work remains.
    busyNext_s = (stateNext_s != IDLE) | ((pwr_req_i ^ onNext_s) != '0);
    if (stateNext_s != state_r) begin
      cntNext_s = '0;
    end else if (state_r inside {ISO, CLKON, DEISO}) begin
      cntNext_s = cnt_r + CntWidth'(1);
    end else begin
      cntNext_s = cnt_r;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      gnt_r   <= '0;
      dir_r   <= 1'b0;
      rr_r    <= '0;
      on_r    <= '1;
      iso_r   <= '0;
      clkEn_r <= '1;
      cRst_r  <= '0;
      err_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
      gnt_r   <= gntNext_s;
      dir_r   <= dirNext_s;
      rr_r    <= rrNext_s;
      on_r    <= onNext_s;
      iso_r   <= isoNext_s;
      clkEn_r <= clkEnNext_s;
      cRst_r  <= cRstNext_s;
      err_r   <= errNext_s;
      busy_r  <= busyNext_s;
    end
  end

  assign isolate_o     = iso_r;
  assign clk_en_o      = clkEn_r;
  assign cluster_rst_o = cRst_r;
  assign on_o          = on_r;
  assign err_o         = err_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Scoreboard bench for chimera_cluster_pwr_seq: directed requests, expected on/err events queued.
module tb_chimera_cluster_pwr_seq;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pwrReq, isolated, isolate, clkEn, clusterRst, on, err;
  logic         errClr, busy;
  logic [N-1:0] d1, d2, d3;
  logic [N-1:0] stuck;

  int checks   = 0;
  int failures = 0;
  int lat, isoAt, clkAt, rstAt, clkOnAt, rstOffAt, isoOffAt, rstHold, busyLow;

  typedef struct {
    int   idx;
    logic val;
    logic isErr;
  } ev_t;
  ev_t expQ[$];

  always #5 clk = ~clk;

  chimera_cluster_pwr_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pwr_req_i     (pwrReq),
    .isolated_i    (isolated),
    .err_clr_i     (errClr),
    .isolate_o     (isolate),
    .clk_en_o      (clkEn),
    .cluster_rst_o (clusterRst),
    .on_o          (on),
    .err_o         (err),
    .busy_o        (busy)
  );

  chimera_cluster_pwr_seq_chk #(.NumClusters(N)) uChk (
    .clk        (clk),
    .rst        (rst),
    .isolate    (isolate),
    .clkEn      (clkEn),
    .clusterRst (clusterRst),
    .on         (on)
  );

  // Isolation cell model: ack follows the request three cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d1 <= isolate;
      d2 <= d1;
      d3 <= d2;
    end
  end
  assign isolated = d3 & ~stuck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic popCmp(input int idx, input logic val, input logic isErr);
    ev_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: cluster %0d val=%b err_event=%b", idx, val, isErr);
    end else begin
      e = expQ.pop_front();
      check("sb_idx", idx, e.idx);
      check("sb_val", {isErr, val}, {e.isErr, e.val});
    end
  endtask

  // Monitor: every committed-state change or new error flag consumes one expected event.
  initial begin
    logic [N-1:0] prevOn, prevErr;
    prevOn  = '1;
    prevErr = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (on[i] !== prevOn[i]) popCmp(i, on[i], 1'b0);
        if (err[i] === 1'b1 && prevErr[i] !== 1'b1) popCmp(i, 1'b1, 1'b1);
      end
      prevOn  = on;
      prevErr = err;
    end
  end

  task automatic waitSettle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy !== 1'b0 || (pwrReq ^ on) !== '0) && n < budget);
    check(name, n < budget, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pwrReq = 5'b11111;
    errClr = 1'b0;
    stuck  = 5'b00000;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_on", on, 5'b11111);
    check("rst_clken", clkEn, 5'b11111);
    check("rst_iso", isolate, 5'b00000);
    check("rst_crst", clusterRst, 5'b00000);
    check("rst_err", err, 5'b00000);
    check("rst_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    check("idle_on", on, 5'b11111);
    check("idle_busy", busy, 1'b0);
    check("idle_iso", isolate, 5'b00000);

    // Power down cluster 2
    expQ.push_back('{2, 1'b0, 1'b0});
    pwrReq = 5'b11011;
    lat = 0; isoAt = 0; clkAt = 0; rstAt = 0;
    while (on[2] !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (isoAt == 0 && isolate[2] === 1'b1) isoAt = lat;
      if (clkAt == 0 && clkEn[2] === 1'b0) clkAt = lat;
      if (rstAt == 0 && clusterRst[2] === 1'b1) rstAt = lat;
    end
    check("pd_latency", lat, 7);
    check("pd_iso_at", isoAt, 1);
    check("pd_clk_at", clkAt, 5);
    check("pd_rst_at", rstAt, 6);
    check("pd_ctl", {isolate[2], clkEn[2], clusterRst[2]}, 3'b101);
    check("pd_others_on", {on[4:3], on[1:0]}, 4'b1111);
    check("pd_others_iso", {isolate[4:3], isolate[1:0]}, 4'b0000);
    waitSettle("pd_settle", 20);

    // Power cluster 2 back up
    expQ.push_back('{2, 1'b1, 1'b0});
    pwrReq = 5'b11111;
    lat = 0; clkOnAt = 0; rstOffAt = 0; isoOffAt = 0; rstHold = 0;
    while (on[2] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (clkOnAt == 0 && clkEn[2] === 1'b1) clkOnAt = lat;
      if (rstOffAt == 0 && clusterRst[2] === 1'b0) rstOffAt = lat;
      if (isoOffAt == 0 && isolate[2] === 1'b0) isoOffAt = lat;
      if (clkEn[2] === 1'b1 && clusterRst[2] === 1'b1) rstHold++;
    end
    check("pu_latency", lat, 14);
    check("pu_clk_at", clkOnAt, 1);
    check("pu_rst_hold", rstHold, 8);
    check("pu_rstoff_at", rstOffAt, 9);
    check("pu_isooff_at", isoOffAt, 10);
    waitSettle("pu_settle", 20);

    // All down from rr = 3: order 3, 4, 0, 1, 2
    expQ.push_back('{3, 1'b0, 1'b0});
    expQ.push_back('{4, 1'b0, 1'b0});
    expQ.push_back('{0, 1'b0, 1'b0});
    expQ.push_back('{1, 1'b0, 1'b0});
    expQ.push_back('{2, 1'b0, 1'b0});
    pwrReq = 5'b00000;
    lat = 0; busyLow = 0;
    do begin
      @(negedge clk);
      lat++;
      if (on !== 5'b00000 && busy !== 1'b1) busyLow++;
    end while ((on !== 5'b00000 || busy !== 1'b0) && lat < 100);
    check("alldown_done", lat < 100, 1'b1);
    check("alldown_busy_gaps", busyLow, 0);
    check("alldown_ctl", {isolate, clkEn, clusterRst}, 15'b11111_00000_11111);

    // All up again, same rotation
    expQ.push_back('{3, 1'b1, 1'b0});
    expQ.push_back('{4, 1'b1, 1'b0});
    expQ.push_back('{0, 1'b1, 1'b0});
    expQ.push_back('{1, 1'b1, 1'b0});
    expQ.push_back('{2, 1'b1, 1'b0});
    pwrReq = 5'b11111;
    waitSettle("allup_settle", 200);
    check("allup_on", on, 5'b11111);

    // Isolation ack stuck low on cluster 1 -> timeout abort
    stuck = 5'b00010;
    expQ.push_back('{1, 1'b1, 1'b1});
    pwrReq = 5'b11101;
    lat = 0;
    while (err[1] !== 1'b1 && lat < 1100) begin
      @(negedge clk);
      lat++;
    end
    check("abort_latency", lat, 1026);
    check("abort_iso", isolate[1], 1'b0);
    check("abort_on", on[1], 1'b1);
    check("abort_clken", clkEn[1], 1'b1);
    lat = 0;
    while (isolate[1] !== 1'b1 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    check("regrant_iso", isolate[1], 1'b1);
    check("regrant_busy", busy, 1'b1);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    check("err_clear", err, 5'b00000);
    stuck = 5'b00000;
    expQ.push_back('{1, 1'b0, 1'b0});
    waitSettle("unstuck_settle", 40);
    check("unstuck_on", on, 5'b11101);
    check("unstuck_err", err, 5'b00000);
    expQ.push_back('{1, 1'b1, 1'b0});
    pwrReq = 5'b11111;
    waitSettle("up1_settle", 40);

    // Request reversed during cluster 0's CLKOFF
    expQ.push_back('{0, 1'b0, 1'b0});
    expQ.push_back('{0, 1'b1, 1'b0});
    pwrReq = 5'b11110;
    lat = 0;
    while (clkEn[0] !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rev_clkoff_seen", clkEn[0], 1'b0);
    pwrReq = 5'b11111;
    waitSettle("rev_settle", 60);
    check("rev_on", on, 5'b11111);
    check("rev_ctl", {isolate, clusterRst}, 10'b00000_00000);

    // Asynchronous reset in the middle of ISO
    pwrReq = 5'b11011;
    lat = 0;
    while (isolate[2] !== 1'b1 && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    check("midiso_seen", isolate[2], 1'b1);
    #2 rst = 1'b1;
    pwrReq = 5'b11111;
    #1;
    check("arst_on", on, 5'b11111);
    check("arst_clken", clkEn, 5'b11111);
    check("arst_iso", isolate, 5'b00000);
    check("arst_crst", clusterRst, 5'b00000);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_on", on, 5'b11111);

    check("sb_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
